// File: rtl/tx_dma_chan_stats_pkg.sv
// Shared constants, FSM state type and width helpers for the TX DMA per-channel statistics block.
package tx_dma_chan_stats_pkg;

    localparam logic [3:0] PKT_LO      = 4'h0;
    localparam logic [3:0] PKT_HI      = 4'h4;
    localparam logic [3:0] BYTE_LO     = 4'h8;
    localparam logic [3:0] BYTE_HI     = 4'hC;
    localparam int         CHAN_STRIDE = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RD_RESP
    } mi_state_e;

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int size_w(input int pkt_size_max);
        return $clog2(pkt_size_max + 1);
    endfunction

    // Upper MI word of a counter zero-extended to 64 bits.
    function automatic logic [31:0] hi_word(input logic [63:0] v);
        return v[63:32];
    endfunction

endpackage

// File: rtl/tx_dma_chan_stats_inc.sv
// Combinational reduction of the accepted MFB regions of one cycle into per-channel packet/byte increments.
module tx_dma_chan_stats_inc
    import tx_dma_chan_stats_pkg::*;
#(
    parameter int MFB_REGIONS = 1,
    parameter int CHANNELS    = 16,
    parameter int CW          = 4,
    parameter int SW          = 13,
    parameter int IW          = 1,
    parameter int BIW         = 14
) (
    input  logic [MFB_REGIONS-1:0]           sof,
    input  logic [MFB_REGIONS*SW-1:0]        pkt_size,
    input  logic [MFB_REGIONS*CW-1:0]        chan,
    input  logic                             src_rdy,
    input  logic                             dst_rdy,
    output logic [CHANNELS-1:0][IW-1:0]      pkt_inc,
    output logic [CHANNELS-1:0][BIW-1:0]     byte_inc
);

    logic [MFB_REGIONS-1:0] acc;
    assign acc = sof & {MFB_REGIONS{src_rdy & dst_rdy}};

    // Channel values outside 0..CHANNELS-1 never match any lane and so drop out.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [IW-1:0]  p;
        logic [BIW-1:0] b;
        always_comb begin
            p = '0;
            b = '0;
            for (int r = 0; r < MFB_REGIONS; r++) begin
                if (acc[r] && chan[r*CW +: CW] == CW'(ch)) begin
                    p = p + IW'(1);
                    b = b + BIW'(pkt_size[r*SW +: SW]);
                end
            end
        end
        assign pkt_inc[ch]  = p;
        assign byte_inc[ch] = b;
    end

endmodule

// File: rtl/tx_dma_chan_stats.sv
// Per-channel packet/byte counters snooped from the USR TX MFB, with MI readout via PKT_LO-triggered snapshots.
module tx_dma_chan_stats
    import tx_dma_chan_stats_pkg::*;
#(
    parameter int MFB_REGIONS  = 1,
    parameter int CHANNELS     = 16,
    parameter int PKT_SIZE_MAX = 2**12,
    parameter int CNTRS_WIDTH  = 64,
    parameter int MI_WIDTH     = 32
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic [MFB_REGIONS-1:0]                     USR_TX_MFB_SOF,
    input  logic [MFB_REGIONS*size_w(PKT_SIZE_MAX)-1:0] USR_TX_MFB_META_PKT_SIZE,
    input  logic [MFB_REGIONS*chan_w(CHANNELS)-1:0]    USR_TX_MFB_META_CHAN,
    input  logic                                       USR_TX_MFB_SRC_RDY,
    input  logic                                       USR_TX_MFB_DST_RDY,
    input  logic [MI_WIDTH-1:0]                        MI_ADDR,
    input  logic [MI_WIDTH-1:0]                        MI_DWR,
    input  logic [MI_WIDTH/8-1:0]                      MI_BE,
    input  logic                                       MI_RD,
    input  logic                                       MI_WR,
    output logic [MI_WIDTH-1:0]                        MI_DRD,
    output logic                                       MI_ARDY,
    output logic                                       MI_DRDY
);

    localparam int CW  = chan_w(CHANNELS);
    localparam int SW  = size_w(PKT_SIZE_MAX);
    localparam int IW  = $clog2(MFB_REGIONS + 1);
    localparam int BIW = SW + IW;
    localparam int AW  = $clog2(CHANNELS) + 4;

    logic [CHANNELS-1:0][IW-1:0]          pkt_inc;
    logic [CHANNELS-1:0][BIW-1:0]         byte_inc;
    logic [CHANNELS-1:0][CNTRS_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [CHANNELS-1:0][31:0]            shd_pkt_hi_q, shd_pkt_hi_d;
    logic [CHANNELS-1:0][31:0]            shd_byte_lo_q, shd_byte_lo_d;
    logic [CHANNELS-1:0][31:0]            shd_byte_hi_q, shd_byte_hi_d;
    logic [MI_WIDTH-1:0]                  drd_q, drd_d;
    mi_state_e                            state_q, state_d;

    logic [CW-1:0] sel_ch;
    logic [3:0]    sel_off;
    logic          addr_oor, rd_hit, rd_lo, clr;
    logic          unused_bits;

    tx_dma_chan_stats_inc #(
        .MFB_REGIONS (MFB_REGIONS),
        .CHANNELS    (CHANNELS),
        .CW          (CW),
        .SW          (SW),
        .IW          (IW),
        .BIW         (BIW)
    ) u_inc (
        .sof      (USR_TX_MFB_SOF),
        .pkt_size (USR_TX_MFB_META_PKT_SIZE),
        .chan     (USR_TX_MFB_META_CHAN),
        .src_rdy  (USR_TX_MFB_SRC_RDY),
        .dst_rdy  (USR_TX_MFB_DST_RDY),
        .pkt_inc  (pkt_inc),
        .byte_inc (byte_inc)
    );

    assign sel_ch      = MI_ADDR[CW+3:4];
    assign sel_off     = {MI_ADDR[3:2], 2'b00};
    assign addr_oor    = |(MI_ADDR >> AW);
    assign rd_hit      = MI_RD & ~addr_oor;
    assign rd_lo       = rd_hit & (sel_off == PKT_LO);
    // A simultaneous read wins; the write half of such an access is dropped.
    assign clr         = MI_WR & ~MI_RD & ~addr_oor & (sel_off == PKT_LO) & (|MI_BE);
    assign unused_bits = ^{MI_DWR, MI_ADDR[1:0]};

    assign MI_ARDY = MI_RD | MI_WR;
    assign MI_DRDY = (state_q == ST_RD_RESP);
    assign MI_DRD  = drd_q;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            // Clear zeroes the base only, so a same-cycle increment still lands.
            if (clr && sel_ch == CW'(i)) begin
                pkt_cnt_d[i]  = '0;
                byte_cnt_d[i] = '0;
            end
            pkt_cnt_d[i]  = pkt_cnt_d[i]  + CNTRS_WIDTH'(pkt_inc[i]);
            byte_cnt_d[i] = byte_cnt_d[i] + CNTRS_WIDTH'(byte_inc[i]);
        end
    end

    always_comb begin
        shd_pkt_hi_d  = shd_pkt_hi_q;
        shd_byte_lo_d = shd_byte_lo_q;
        shd_byte_hi_d = shd_byte_hi_q;
        if (rd_lo) begin
            shd_pkt_hi_d[sel_ch]  = hi_word(64'(pkt_cnt_q[sel_ch]));
            shd_byte_lo_d[sel_ch] = byte_cnt_q[sel_ch][31:0];
            shd_byte_hi_d[sel_ch] = hi_word(64'(byte_cnt_q[sel_ch]));
        end
    end

    always_comb begin
        drd_d   = '0;
        state_d = MI_RD ? ST_RD_RESP : ST_IDLE;
        if (rd_hit) begin
            case (sel_off)
                PKT_LO:  drd_d = pkt_cnt_q[sel_ch][31:0];
                PKT_HI:  drd_d = shd_pkt_hi_q[sel_ch];
                BYTE_LO: drd_d = shd_byte_lo_q[sel_ch];
                default: drd_d = shd_byte_hi_q[sel_ch];
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pkt_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shd_pkt_hi_q  <= '0;
            shd_byte_lo_q <= '0;
            shd_byte_hi_q <= '0;
            drd_q         <= '0;
            state_q       <= ST_IDLE;
        end else begin
            pkt_cnt_q     <= pkt_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            shd_pkt_hi_q  <= shd_pkt_hi_d;
            shd_byte_lo_q <= shd_byte_lo_d;
            shd_byte_hi_q <= shd_byte_hi_d;
            drd_q         <= drd_d;
            state_q       <= state_d;
        end
    end

endmodule

// File: tb/tb_tx_dma_chan_stats.sv
// Scoreboard bench for tx_dma_chan_stats: reads push expected words, a negedge monitor pops on MI_DRDY.
module tb_tx_dma_chan_stats;

    localparam int R   = 2;
    localparam int CH  = 8;
    localparam int PSM = 2**20;
    localparam int CNW = 33;
    localparam int SW  = 21;
    localparam int CW  = 3;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [R-1:0]    SOF = '0;
    logic [R*SW-1:0] SIZE = '0;
    logic [R*CW-1:0] CHAN = '0;
    logic            SRC = 1'b0, DST = 1'b0;
    logic [31:0]     MI_ADDR = '0, MI_DWR = '0, MI_DRD;
    logic [3:0]      MI_BE = '0;
    logic            MI_RD = 1'b0, MI_WR = 1'b0, MI_ARDY, MI_DRDY;

    typedef struct {
        logic [31:0] val;
        int          due;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    tx_dma_chan_stats #(
        .MFB_REGIONS (R), .CHANNELS (CH), .PKT_SIZE_MAX (PSM), .CNTRS_WIDTH (CNW), .MI_WIDTH (32)
    ) dut (
        .CLK (CLK), .RESET (RESET),
        .USR_TX_MFB_SOF (SOF), .USR_TX_MFB_META_PKT_SIZE (SIZE), .USR_TX_MFB_META_CHAN (CHAN),
        .USR_TX_MFB_SRC_RDY (SRC), .USR_TX_MFB_DST_RDY (DST),
        .MI_ADDR (MI_ADDR), .MI_DWR (MI_DWR), .MI_BE (MI_BE), .MI_RD (MI_RD), .MI_WR (MI_WR),
        .MI_DRD (MI_DRD), .MI_ARDY (MI_ARDY), .MI_DRDY (MI_DRDY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: each queued read must return on its due cycle; any other DRDY is spurious.
    always @(negedge CLK) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (!MI_DRDY) begin
                errors++;
                $display("FAIL rd#%0d drdy: got 0 expected 1", e.tag);
            end else if (MI_DRD !== e.val) begin
                errors++;
                $display("FAIL rd#%0d data: got %0h expected %0h", e.tag, MI_DRD, e.val);
            end
        end else if (MI_DRDY) begin
            checks++;
            errors++;
            $display("FAIL spurious_drdy: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    int rd_tag = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic step();
        @(negedge CLK);
        if (MI_RD || MI_WR) chk("ardy", {31'b0, MI_ARDY}, 32'd1);
        @(posedge CLK);
        #1;
        MI_RD = 0; MI_WR = 0; MI_BE = '0;
        SOF = '0; SRC = 0; DST = 0;
    endtask

    task automatic rd_set(input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        MI_RD   = 1;
        MI_ADDR = addr;
        e.val = exp; e.due = cyc + 1; e.tag = rd_tag++;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        rd_set(addr, exp);
        step();
    endtask

    task automatic wr_set(input logic [31:0] addr, input logic [3:0] be);
        MI_WR = 1; MI_ADDR = addr; MI_BE = be; MI_DWR = 32'hDEAD_BEEF;
    endtask

    task automatic pk_set(input logic [1:0] sof, input logic [2:0] c0, input logic [20:0] s0,
                          input logic [2:0] c1, input logic [20:0] s1, input logic src, input logic dst);
        SOF = sof; CHAN = {c1, c0}; SIZE = {s1, s0}; SRC = src; DST = dst;
    endtask

    initial begin
        // Reset state
        @(negedge CLK);
        chk("rst_drdy", {31'b0, MI_DRDY}, 32'd0);
        chk("rst_drd", MI_DRD, 32'd0);
        chk("ardy_idle", {31'b0, MI_ARDY}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        rd(32'h00, 32'd0);

        // Two SOFs on ch3 in one cycle
        pk_set(2'b11, 3, 60, 3, 1500, 1, 1); step();
        rd(32'h30, 32'd2);
        rd(32'h34, 32'd0);
        rd(32'h38, 32'd1560);
        rd(32'h3C, 32'd0);
        rd(32'h20, 32'd0);
        rd(32'h70, 32'd0);

        // Not accepted: DST_RDY low, SRC_RDY low, SOF low
        pk_set(2'b11, 3, 60, 3, 1500, 1, 0); step();
        pk_set(2'b11, 3, 60, 3, 1500, 0, 1); step();
        pk_set(2'b00, 3, 60, 3, 1500, 1, 1); step();
        rd(32'h30, 32'd2);
        rd(32'h38, 32'd1560);

        // Single region 1 on ch1; regions split across ch4/ch6
        pk_set(2'b10, 0, 999, 1, 100, 1, 1); step();
        pk_set(2'b11, 4, 7, 6, 9, 1, 1); step();
        rd(32'h10, 32'd1); rd(32'h18, 32'd100);
        rd(32'h40, 32'd1); rd(32'h48, 32'd7);
        rd(32'h60, 32'd1); rd(32'h68, 32'd9);
        rd(32'h00, 32'd0);

        // Out-of-range address reads zero; back-to-back with a write there
        rd(32'h80, 32'd0);
        wr_set(32'h80, 4'hF); step();
        rd(32'h1000, 32'd0);

        // Byte counter on ch5 crosses 2**32 then wraps at 2**33
        for (int i = 0; i < 2048; i++) begin
            pk_set(2'b11, 5, 21'(PSM), 5, 21'(PSM), 1, 1); step();
        end
        rd(32'h50, 32'd4096); rd(32'h54, 32'd0);
        rd(32'h58, 32'd0);    rd(32'h5C, 32'd1);
        for (int i = 0; i < 2048; i++) begin
            pk_set(2'b11, 5, 21'(PSM), 5, 21'(PSM), 1, 1); step();
        end
        rd(32'h50, 32'd8192); rd(32'h58, 32'd0); rd(32'h5C, 32'd0);

        // Snapshot in the same cycle as an increment keeps the pre-increment value
        rd_set(32'h50, 32'd8192); pk_set(2'b01, 5, 10, 0, 0, 1, 1); step();
        rd(32'h58, 32'd0);
        rd(32'h50, 32'd8193);
        rd(32'h58, 32'd10);

        // Clear racing an increment on ch2
        pk_set(2'b01, 2, 500, 0, 0, 1, 1); step();
        wr_set(32'h20, 4'hF); pk_set(2'b01, 2, 64, 0, 0, 1, 1); step();
        rd(32'h20, 32'd1); rd(32'h28, 32'd64);
        wr_set(32'h20, 4'h0); step();
        rd(32'h20, 32'd1);
        wr_set(32'h24, 4'hF); step();
        rd(32'h20, 32'd1);
        rd_set(32'h20, 32'd1); MI_WR = 1; MI_BE = 4'hF; step();
        rd(32'h20, 32'd1);
        wr_set(32'h20, 4'h1); step();
        rd(32'h28, 32'd64);
        rd(32'h20, 32'd0);
        rd(32'h28, 32'd0);

        // Reset between RD and DRDY drops the response
        MI_RD = 1; MI_ADDR = 32'h50;
        @(posedge CLK);
        #1 MI_RD = 0; RESET = 1;
        @(negedge CLK);
        chk("rst_mid_drdy", {31'b0, MI_DRDY}, 32'd0);
        @(posedge CLK);
        #1 RESET = 0;
        rd(32'h38, 32'd0);
        rd(32'h50, 32'd0); rd(32'h58, 32'd0);
        rd(32'h30, 32'd0); rd(32'h10, 32'd0);

        repeat (3) @(posedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
